mos_nand_cell: RTL and testbench

- N-input CMOS NAND cell modelled at switch level: parallel PMOS pull-up network to supply1, series NMOS pull-down chain to supply0.
- Models four-state (0/1/X/Z) gate inputs and a sleep (power-gate) control.
- Provides a combinational output and a clocked, resettable registered copy.
- Used as a library primitive and as a golden model for transistor-level gate checks.

---
 rtl/mos_nand_cell_pkg.sv | 56 +++++
 rtl/mos_nand_cell_if.sv | 26 ++
 rtl/mos_nand_cell_switch.sv | 23 ++
 rtl/mos_nand_cell.sv | 70 +++++++
 tb/tb_mos_nand_cell.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/mos_nand_cell_pkg.sv
// Shared types for the switch-level NAND cell: encoded four-state values,
// network states and the node/sleep resolution helpers.
package mos_pkg;

    // Four-state value carried as a 2-bit code so X and Z survive 2-state flows.
    typedef logic [1:0] lv_t;
    localparam lv_t LV_0 = 2'b00;
    localparam lv_t LV_1 = 2'b01;
    localparam lv_t LV_Z = 2'b10;
    localparam lv_t LV_X = 2'b11;

    localparam int N_IN_MAX = 8;

    typedef enum logic [1:0] {
        NET_OFF   = 2'd0,
        NET_ON    = 2'd1,
        NET_MAYBE = 2'd2
    } net_state_t;

    function automatic lv_t resolve_node(input net_state_t up, input net_state_t down);
        lv_t node;
        node = LV_X;
        if (up == NET_ON && down == NET_OFF) begin
            node = LV_1;
        end else if (up == NET_OFF && down == NET_ON) begin
            node = LV_0;
        end else if (up == NET_OFF && down == NET_OFF) begin
            node = LV_Z;
        end
        return node;
    endfunction

    // Unknown sleep may or may not cut the rail, so a conducting network becomes MAYBE.
    function automatic net_state_t gate_sleep(input net_state_t net, input lv_t sleep);
        net_state_t gated;
        gated = net;
        if (sleep == LV_1) begin
            gated = NET_OFF;
        end else if (sleep != LV_0 && net == NET_ON) begin
            gated = NET_MAYBE;
        end
        return gated;
    endfunction

    function automatic net_state_t switch_state(input lv_t out);
        net_state_t st;
        st = NET_ON;
        if (out == LV_Z) begin
            st = NET_OFF;
        end else if (out == LV_X) begin
            st = NET_MAYBE;
        end
        return st;
    endfunction

endpackage

// File: rtl/mos_nand_cell_if.sv
// Cell-side bundle: gate inputs, sleep, combinational node, registered copy,
// plus the resolved network states for observation.
interface mos_nand_cell_if
    import mos_pkg::*;
#(
    parameter int N_IN = 2
) ();
    // in/sleep are driven by the master and sampled combinationally; y/q and
    // the network states are always-valid outputs of the cell (no handshake).
    lv_t [N_IN-1:0] in;
    lv_t            sleep;
    lv_t            y;
    lv_t            q;
    net_state_t     up_st;
    net_state_t     dn_st;

    modport master (
        output in, sleep,
        input  y, q, up_st, dn_st
    );

    modport slave (
        input  in, sleep,
        output y, q, up_st, dn_st
    );
endinterface

// File: rtl/mos_nand_cell_switch.sv
// Single MOS transistor: passes data when the gate turns it on, floats when
// off, and is unknown when the gate is X/Z.
module mos_switch
    import mos_pkg::*;
#(
    parameter bit IS_PMOS = 1'b0
) (
    input  lv_t gate,
    input  lv_t data,
    output lv_t out
);
    localparam lv_t ON_LVL  = IS_PMOS ? LV_0 : LV_1;
    localparam lv_t OFF_LVL = IS_PMOS ? LV_1 : LV_0;

    always_comb begin
        out = LV_X;
        if (gate == ON_LVL) begin
            out = data;
        end else if (gate == OFF_LVL) begin
            out = LV_Z;
        end
    end
endmodule

// File: rtl/mos_nand_cell.sv
// N-input CMOS NAND: parallel PMOS pull-up, series NMOS pull-down, sleep gating,
// four-state node resolution and a charge-retaining output register.
module mos_nand_cell
    import mos_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic           clk,
    input  logic           rst,
    mos_nand_cell_if.slave bus
);
    lv_t [N_IN-1:0] pu_out;
    lv_t [N_IN-1:0] pd_out;
    net_state_t     up_raw;
    net_state_t     dn_raw;
    net_state_t     up_st;
    net_state_t     dn_st;
    lv_t            y;
    lv_t            q_d;
    lv_t            q_q;
    logic           pu_any_on;
    logic           pu_all_off;
    logic           pd_all_on;
    logic           pd_any_off;

    for (genvar g = 0; g < N_IN; g++) begin : g_dev
        mos_switch #(.IS_PMOS(1'b1)) u_pmos (.gate(bus.in[g]), .data(LV_1), .out(pu_out[g]));
        mos_switch #(.IS_PMOS(1'b0)) u_nmos (.gate(bus.in[g]), .data(LV_0), .out(pd_out[g]));
    end

    // Parallel pull-up conducts if any device does; series pull-down needs all.
    always_comb begin
        pu_any_on  = 1'b0;
        pu_all_off = 1'b1;
        pd_all_on  = 1'b1;
        pd_any_off = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (switch_state(pu_out[i]) == NET_ON)  pu_any_on  = 1'b1;
            if (switch_state(pu_out[i]) != NET_OFF) pu_all_off = 1'b0;
            if (switch_state(pd_out[i]) != NET_ON)  pd_all_on  = 1'b0;
            if (switch_state(pd_out[i]) == NET_OFF) pd_any_off = 1'b1;
        end
        up_raw = pu_any_on ? NET_ON : (pu_all_off ? NET_OFF : NET_MAYBE);
        dn_raw = pd_all_on ? NET_ON : (pd_any_off ? NET_OFF : NET_MAYBE);
        up_st  = gate_sleep(up_raw, bus.sleep);
        dn_st  = gate_sleep(dn_raw, bus.sleep);
        y      = resolve_node(up_st, dn_st);
    end

    // A floating node leaves the stored charge in place.
    always_comb begin
        q_d = y;
        if (y == LV_Z) begin
            q_d = q_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= LV_1;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.y     = y;
    assign bus.q     = q_q;
    assign bus.up_st = up_st;
    assign bus.dn_st = dn_st;
endmodule

// File: tb/tb_mos_nand_cell.sv
// Directed bench for mos_nand_cell: a 2-input instance for the four-state and
// sleep/reset sequences, and a 4-input instance for the exhaustive sweep.
module tb_mos_nand_cell;
    import mos_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    lv_t  exp_q[$];

    mos_nand_cell_if #(.N_IN(2)) bus2 ();
    mos_nand_cell_if #(.N_IN(4)) bus4 ();

    mos_nand_cell #(.N_IN(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mos_nand_cell #(.N_IN(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string lv_str(input lv_t v);
        case (v)
            LV_0:    return "0";
            LV_1:    return "1";
            LV_Z:    return "Z";
            default: return "X";
        endcase
    endfunction

    task automatic check(input string tag, input lv_t got, input lv_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%s exp=%s", tag, lv_str(got), lv_str(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input lv_t b1, input lv_t b0, input lv_t slp);
        bus2.in    = {b1, b0};
        bus2.sleep = slp;
        #1;
    endtask

    // Queue the expected registered value, clock once, then score it.
    task automatic clock_check(input string tag, input int sel, input lv_t exp);
        lv_t e;
        exp_q.push_back(exp);
        tick();
        e = exp_q.pop_front();
        if (sel == 4) check(tag, bus4.q, e);
        else          check(tag, bus2.q, e);
    endtask

    initial begin
        rst        = 1'b1;
        bus4.in    = {LV_1, LV_1, LV_1, LV_1};
        bus4.sleep = LV_0;
        drive2(LV_1, LV_1, LV_0);

        // reset with in=11 for two cycles
        tick();
        check("rst_q_c1", bus2.q, LV_1);
        tick();
        check("rst_q_c2", bus2.q, LV_1);
        check("rst_q4", bus4.q, LV_1);
        check("rst_y11", bus2.y, LV_0);
        rst = 1'b0;
        clock_check("rel_q", 2, LV_0);

        // known 2-input truth table
        drive2(LV_0, LV_0, LV_0);
        check("y_00", bus2.y, LV_1);
        clock_check("q_00", 2, LV_1);
        drive2(LV_0, LV_1, LV_0);
        check("y_01", bus2.y, LV_1);
        clock_check("q_01", 2, LV_1);
        drive2(LV_1, LV_0, LV_0);
        check("y_10", bus2.y, LV_1);
        clock_check("q_10", 2, LV_1);
        drive2(LV_1, LV_1, LV_0);
        check("y_11", bus2.y, LV_0);
        clock_check("q_11", 2, LV_0);

        // unknown gate inputs
        drive2(LV_1, LV_X, LV_0);
        check("y_1x", bus2.y, LV_X);
        clock_check("q_1x", 2, LV_X);
        drive2(LV_0, LV_X, LV_0);
        check("y_0x", bus2.y, LV_1);
        clock_check("q_0x", 2, LV_1);
        drive2(LV_Z, LV_Z, LV_0);
        check("y_zz", bus2.y, LV_X);
        clock_check("q_zz", 2, LV_X);
        drive2(LV_Z, LV_0, LV_0);
        check("y_z0", bus2.y, LV_1);

        // sleep floats the node; q keeps its charge
        drive2(LV_1, LV_1, LV_0);
        clock_check("q_pre_sleep", 2, LV_0);
        drive2(LV_1, LV_1, LV_1);
        check("y_sleep", bus2.y, LV_Z);
        for (int c = 0; c < 3; c++) clock_check("q_hold", 2, LV_0);
        drive2(LV_0, LV_0, LV_1);
        check("y_sleep00", bus2.y, LV_Z);
        clock_check("q_hold00", 2, LV_0);
        drive2(LV_0, LV_0, LV_0);
        check("y_wake", bus2.y, LV_1);
        clock_check("q_wake", 2, LV_1);

        // unknown sleep
        drive2(LV_1, LV_1, LV_X);
        check("y_slx_11", bus2.y, LV_X);
        drive2(LV_0, LV_0, LV_X);
        check("y_slx_00", bus2.y, LV_X);
        drive2(LV_0, LV_1, LV_Z);
        check("y_slz_01", bus2.y, LV_X);

        // reset mid-sequence while y=0
        drive2(LV_1, LV_1, LV_0);
        clock_check("q_mid_pre", 2, LV_0);
        rst = 1'b1;
        clock_check("q_mid_rst", 2, LV_1);
        check("y_mid_rst", bus2.y, LV_0);
        rst = 1'b0;
        clock_check("q_mid_rel", 2, LV_0);

        // 4-input exhaustive sweep of known inputs
        for (int v = 0; v < 16; v++) begin
            lv_t [3:0] vec;
            for (int b = 0; b < 4; b++) vec[b] = v[b] ? LV_1 : LV_0;
            bus4.in = vec;
            #1;
            check($sformatf("y4_%0d", v), bus4.y, (v == 15) ? LV_0 : LV_1);
            clock_check($sformatf("q4_%0d", v), 4, (v == 15) ? LV_0 : LV_1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
